// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: coarse time-to-digital measurement sequencer.
// Synchronizes the asynchronous start/stop hits, counts clk cycles between
// their rising edges, closes on stop or timeout and hands the result to the
// readout side over valid/ready. Supports single-shot and continuous re-arm.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   arm             level, sampled in IDLE to begin a measurement cycle
//   abort           level, returns to IDLE from any state (highest priority
//                   after rst)
//   continuous      1 = re-arm after each result handshake
//   start, stop     asynchronous hit inputs
//   busy            state is not IDLE
//   result          coarse interval in clk cycles
//   result_timeout  result was closed by timeout rather than by stop
//   result_valid    result available
//   result_ready    consumer accepts result
//   meas_count      number of handshaked results, wraps at 16 bits
//   overrun         sticky: a start hit arrived while a result was pending
module tdc_meas_ctrl #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 continuous,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] result,
  output logic                 result_timeout,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [15:0]          meas_count,
  output logic                 overrun
);

  localparam int unsigned MC_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n;
  logic [CNT_WIDTH-1:0]   result_n;
  logic                   timeout_n;
  logic [MC_W-1:0]        mc_n;
  logic                   overrun_n;

  logic [SYNC_STAGES-1:0] start_sync, stop_sync;
  logic                   start_d, stop_d;
  logic                   start_p, stop_p;

  // Hit synchronizers plus one edge-detect flop; both paths have equal latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_sync <= '0;
      stop_sync  <= '0;
      start_d    <= 1'b0;
      stop_d     <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], start};
      stop_sync  <= {stop_sync[SYNC_STAGES-2:0], stop};
      start_d    <= start_sync[SYNC_STAGES-1];
      stop_d     <= stop_sync[SYNC_STAGES-1];
    end
  end

  assign start_p = start_sync[SYNC_STAGES-1] & ~start_d;
  assign stop_p  = stop_sync[SYNC_STAGES-1] & ~stop_d;

  // Next-state and datapath update.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    result_n  = result;
    timeout_n = result_timeout;
    mc_n      = meas_count;
    overrun_n = overrun;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (arm) begin
            state_n   = S_ARMED;
            overrun_n = 1'b0;
          end
        end
        S_ARMED: begin
          // A simultaneous stop is dropped; only start opens the window.
          if (start_p) begin
            state_n = S_RUN;
            cnt_n   = CNT_WIDTH'(1);
          end
        end
        S_RUN: begin
          // Stop takes precedence over a timeout in the same cycle.
          if (stop_p) begin
            result_n  = cnt;
            timeout_n = 1'b0;
            state_n   = S_DONE;
          end else if (cnt == CNT_WIDTH'(TIMEOUT)) begin
            result_n  = CNT_WIDTH'(TIMEOUT);
            timeout_n = 1'b1;
            state_n   = S_DONE;
          end else begin
            cnt_n = cnt + CNT_WIDTH'(1);
          end
        end
        S_DONE: begin
          if (start_p) overrun_n = 1'b1;
          if (result_ready) begin
            mc_n    = meas_count + MC_W'(1);
            state_n = continuous ? S_ARMED : S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and output registers; busy/valid are registered decodes of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      result         <= '0;
      result_timeout <= 1'b0;
      result_valid   <= 1'b0;
      busy           <= 1'b0;
      meas_count     <= '0;
      overrun        <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      result         <= result_n;
      result_timeout <= timeout_n;
      result_valid   <= (state_n == S_DONE);
      busy           <= (state_n != S_IDLE);
      meas_count     <= mc_n;
      overrun        <= overrun_n;
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl (SYNC_STAGES=2, TIMEOUT=100).
module tb_tdc_meas_ctrl;

  localparam int unsigned CW = 16;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          rst, arm, abort, continuous, start, stop, result_ready;
  logic          busy, result_timeout, result_valid, overrun;
  logic [CW-1:0] result;
  logic [15:0]   meas_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  tdc_meas_ctrl #(.CNT_WIDTH(CW), .TIMEOUT(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .continuous(continuous),
    .start(start), .stop(stop), .busy(busy), .result(result),
    .result_timeout(result_timeout), .result_valid(result_valid),
    .result_ready(result_ready), .meas_count(meas_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Start pin rises now, stop pin rises gap cycles later, optional extra start
  // at cycle 'extra'. Returns on the edge where the stop pulse is sampled.
  task automatic hits(input int gap, input int extra);
    for (int i = 0; i < gap + 3; i++) begin
      start = (i < 2) || (extra > 0 && i >= extra && i < extra + 2);
      stop  = (i >= gap && i < gap + 2);
      tick(1);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    tick(1);
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; continuous = 1'b0;
    start = 1'b0; stop = 1'b0; result_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_timeout", 32'(result_timeout), 0);
    check("rst_count", 32'(meas_count), 0);
    check("rst_overrun", 32'(overrun), 0);

    // Basic 37-cycle interval, single-shot
    do_arm();
    check("arm_busy", 32'(busy), 1);
    hits(37, 0);
    check("m37_valid", 32'(result_valid), 1);
    check("m37_result", 32'(result), 37);
    check("m37_timeout", 32'(result_timeout), 0);
    tick(3);
    check("m37_hold_valid", 32'(result_valid), 1);
    check("m37_hold_result", 32'(result), 37);
    handshake();
    check("m37_hs_valid", 32'(result_valid), 0);
    check("m37_hs_busy", 32'(busy), 0);
    check("m37_hs_count", 32'(meas_count), 1);

    // Start only: timeout at counter=100
    do_arm();
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(100);
    check("to_not_yet", 32'(result_valid), 0);
    tick(1);
    check("to_valid", 32'(result_valid), 1);
    check("to_result", 32'(result), 100);
    check("to_flag", 32'(result_timeout), 1);
    handshake();

    // Stop exactly at counter=100: stop wins
    do_arm();
    hits(100, 0);
    check("edge_valid", 32'(result_valid), 1);
    check("edge_result", 32'(result), 100);
    check("edge_timeout", 32'(result_timeout), 0);
    handshake();
    check("edge_count", 32'(meas_count), 3);

    // Stop before start ignored; extra start in RUN ignored
    do_arm();
    stop = 1'b1;
    tick(2);
    stop = 1'b0;
    tick(3);
    check("early_stop_busy", 32'(busy), 1);
    check("early_stop_valid", 32'(result_valid), 0);
    hits(20, 6);
    check("extra_start_result", 32'(result), 20);
    check("extra_start_timeout", 32'(result_timeout), 0);
    handshake();

    // Start and stop together: stays in RUN, times out
    do_arm();
    hits(0, 0);
    check("together_busy", 32'(busy), 1);
    check("together_valid", 32'(result_valid), 0);
    tick(99);
    check("together_not_yet", 32'(result_valid), 0);
    tick(1);
    check("together_result", 32'(result), 100);
    check("together_timeout", 32'(result_timeout), 1);
    handshake();
    check("together_count", 32'(meas_count), 5);

    // Continuous mode with overrun during a stalled DONE
    continuous = 1'b1;
    do_arm();
    hits(10, 0);
    check("cont_result", 32'(result), 10);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(18);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_result", 32'(result), 10);
    check("ovr_valid", 32'(result_valid), 1);
    handshake();
    check("cont_rearm_busy", 32'(busy), 1);
    check("cont_rearm_valid", 32'(result_valid), 0);
    check("cont_count", 32'(meas_count), 6);
    hits(5, 0);
    check("cont_m5_result", 32'(result), 5);
    check("cont_ovr_sticky", 32'(overrun), 1);
    handshake();
    continuous = 1'b0;
    check("cont_count2", 32'(meas_count), 7);

    // Abort during RUN (state is ARMED after continuous handshake)
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(6);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_run_busy", 32'(busy), 0);
    check("abort_run_valid", 32'(result_valid), 0);
    check("abort_run_count", 32'(meas_count), 7);
    do_arm();
    check("arm_clears_ovr", 32'(overrun), 0);

    // Abort during DONE
    hits(8, 0);
    check("pre_abort_valid", 32'(result_valid), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_done_busy", 32'(busy), 0);
    check("abort_done_valid", 32'(result_valid), 0);
    check("abort_done_result", 32'(result), 8);
    check("abort_done_count", 32'(meas_count), 7);

    // Reset in the middle of RUN
    do_arm();
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_result", 32'(result), 0);
    check("midrst_count", 32'(meas_count), 0);
    check("midrst_valid", 32'(result_valid), 0);

    // meas_count wrap: preload near the top, then two handshakes
    force dut.meas_count = 16'hFFFE;
    tick(1);
    release dut.meas_count;
    tick(1);
    check("wrap_preload", 32'(meas_count), 32'h0000FFFE);
    continuous   = 1'b1;
    result_ready = 1'b1;
    do_arm();
    hits(3, 0);
    tick(1);
    check("wrap_ffff", 32'(meas_count), 32'h0000FFFF);
    hits(3, 0);
    tick(1);
    check("wrap_zero", 32'(meas_count), 0);
    result_ready = 1'b0;
    continuous   = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
